// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
//   Bundle of the signals that pass between the multi-cycle RV32I sequencer
//   and its datapath.
//
//   master : the sequencer. It receives instr, branch_taken and dm_ready, and
//            drives every strobe, select, register index and status flag.
//   slave  : the datapath side. It drives the inputs of the sequencer and
//            receives its outputs.
//
//   Signals
//     instr          instruction-memory output for the current PC
//     branch_taken   branch-unit result, valid in EXEC
//     dm_ready       data memory finished the current access
//     pc_we/pc_sel   PC load strobe / 0 = PC+4, 1 = ALU target
//     rf_we          register-file write enable
//     dm_we/dm_re    data-memory write / read request
//     rs1/rs2/rd     register indices
//     func3          ALU / DM control
//     subsra         ALU sub / sra select
//     mux_pc_reg1op  1 = rs1, 0 = PC into ALU operand 1
//     mux_imm_reg2op 1 = imm, 0 = rs2 into ALU operand 2
//     mux_wb_sel     00 = DM, 01 = ALU, 10 = PC+4
//     br_opcode      branch-unit op (11111 never, 01111 always)
//     state          FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
//     halted         high in HALT
//     illegal        sticky, unknown opcode caused the halt
//     bus_err        sticky, MEM timeout caused the halt
//     instret        retired-instruction count
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
  parameter int INSTRET_W = 32
);
  logic [31:0]          instr;
  logic                 branch_taken;
  logic                 dm_ready;

  logic                 pc_we;
  logic                 pc_sel;
  logic                 rf_we;
  logic                 dm_we;
  logic                 dm_re;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [4:0]           rd;
  logic [2:0]           func3;
  logic                 subsra;
  logic                 mux_pc_reg1op;
  logic                 mux_imm_reg2op;
  logic [1:0]           mux_wb_sel;
  logic [4:0]           br_opcode;
  logic [2:0]           state;
  logic                 halted;
  logic                 illegal;
  logic                 bus_err;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  instr, branch_taken, dm_ready,
    output pc_we, pc_sel, rf_we, dm_we, dm_re,
    output rs1, rs2, rd, func3, subsra,
    output mux_pc_reg1op, mux_imm_reg2op, mux_wb_sel, br_opcode,
    output state, halted, illegal, bus_err, instret
  );

  modport slave (
    output instr, branch_taken, dm_ready,
    input  pc_we, pc_sel, rf_we, dm_we, dm_re,
    input  rs1, rs2, rd, func3, subsra,
    input  mux_pc_reg1op, mux_imm_reg2op, mux_wb_sel, br_opcode,
    input  state, halted, illegal, bus_err, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for an RV32I datapath. Each instruction walks
//   FETCH -> DECODE -> EXEC [-> MEM] [-> WB] and the controller drives every
//   write strobe and mux select of the datapath. Data-memory accesses wait
//   for dm_ready with a bounded timeout; unknown opcodes, an all-zero word
//   and a memory timeout park the machine in HALT until reset.
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    multicycle_ctrl_if.master (all datapath-facing signals)
//
//   Parameters
//     MEM_TIMEOUT  MEM cycles allowed without dm_ready before bus error (1..255)
//     INSTRET_W    width of the retired-instruction counter
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input logic                clk,
  input logic                reset,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Instruction classes that change the sequencing; R, I-ALU and LUI all
  // behave identically once decoded.
  typedef enum logic [2:0] {
    C_ALU    = 3'd0,
    C_LOAD   = 3'd1,
    C_STORE  = 3'd2,
    C_BRANCH = 3'd3,
    C_JUMP   = 3'd4
  } op_class_e;

  typedef struct packed {
    op_class_e  cls;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] func3;
    logic       subsra;
    logic       sel1;   // 1 = rs1, 0 = PC
    logic       sel2;   // 1 = imm, 0 = rs2
    logic [1:0] wb;
    logic [4:0] br;
  } dec_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] WB_DM  = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [4:0] BR_NEVER  = 5'b11111;
  localparam logic [4:0] BR_ALWAYS = 5'b01111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e               state;
  logic [31:0]          ir;
  dec_t                 dec;
  dec_t                 dec_n;
  logic                 op_ok;
  logic [7:0]           wait_cnt;
  logic [INSTRET_W-1:0] instret;
  logic                 illegal;
  logic                 bus_err;

  logic                 pc_we;
  logic                 pc_sel;
  logic                 rf_we;
  logic                 dm_we;
  logic                 dm_re;

  // Immediate bits the controller never looks at (the immediate unit has
  // its own copy of the instruction word).
  logic unused_ir;
  assign unused_ir = ^{ir[31], ir[29:25]};

  // Decode of the held instruction word; captured into dec when DECODE ends.
  always_comb begin
    dec_n       = '0;
    dec_n.cls   = C_ALU;
    dec_n.rs1   = ir[19:15];
    dec_n.rs2   = ir[24:20];
    dec_n.rd    = ir[11:7];
    dec_n.func3 = ir[14:12];
    dec_n.wb    = WB_ALU;
    dec_n.br    = BR_NEVER;
    op_ok       = 1'b1;
    case (ir[6:0])
      OP_R: begin
        dec_n.sel1   = 1'b1;
        dec_n.sel2   = 1'b0;
        dec_n.subsra = ir[30];
      end
      OP_I: begin
        dec_n.sel1   = 1'b1;
        dec_n.sel2   = 1'b1;
        // Only SRAI carries a meaningful bit 30; for ADDI etc. it is immediate.
        dec_n.subsra = (ir[14:12] == 3'b101) ? ir[30] : 1'b0;
      end
      OP_LOAD: begin
        dec_n.cls  = C_LOAD;
        dec_n.sel1 = 1'b1;
        dec_n.sel2 = 1'b1;
        dec_n.wb   = WB_DM;
      end
      OP_STORE: begin
        dec_n.cls  = C_STORE;
        dec_n.sel1 = 1'b1;
        dec_n.sel2 = 1'b1;
        dec_n.rd   = 5'd0;
      end
      OP_BRANCH: begin
        dec_n.cls  = C_BRANCH;
        dec_n.sel1 = 1'b0;
        dec_n.sel2 = 1'b1;
        dec_n.br   = {2'b00, ir[14:12]};
      end
      OP_JALR: begin
        dec_n.cls  = C_JUMP;
        dec_n.sel1 = 1'b1;
        dec_n.sel2 = 1'b1;
        dec_n.wb   = WB_PC4;
        dec_n.br   = BR_ALWAYS;
      end
      OP_JAL: begin
        dec_n.cls  = C_JUMP;
        dec_n.sel1 = 1'b0;
        dec_n.sel2 = 1'b1;
        dec_n.wb   = WB_PC4;
        dec_n.br   = BR_ALWAYS;
      end
      OP_LUI: begin
        dec_n.sel1 = 1'b0;
        dec_n.sel2 = 1'b1;
      end
      default: op_ok = 1'b0;
    endcase
  end

  // Strobes depend only on the state, the decode register and the two
  // same-cycle datapath responses.
  always_comb begin
    pc_we  = 1'b0;
    pc_sel = 1'b0;
    rf_we  = 1'b0;
    dm_we  = 1'b0;
    dm_re  = 1'b0;
    case (state)
      S_EXEC: begin
        if (dec.cls == C_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = bus.branch_taken;
        end
      end
      S_MEM: begin
        dm_re = (dec.cls == C_LOAD);
        dm_we = (dec.cls == C_STORE);
        // A store retires in the cycle its write completes.
        pc_we = (dec.cls == C_STORE) && bus.dm_ready;
      end
      S_WB: begin
        rf_we  = (dec.rd != 5'd0);
        pc_we  = 1'b1;
        pc_sel = (dec.cls == C_JUMP);
      end
      default: ;
    endcase
  end

  // Every PC update marks the end of an instruction, so pc_we doubles as the
  // retire pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      ir       <= '0;
      dec      <= '0;
      wait_cnt <= '0;
      instret  <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (pc_we) instret <= instret + INSTRET_W'(1);
      case (state)
        S_FETCH: begin
          ir    <= bus.instr;
          state <= S_DECODE;
        end
        S_DECODE: begin
          dec <= dec_n;
          if (op_ok) begin
            state <= S_EXEC;
          end else begin
            state <= S_HALT;
            // An all-zero word is treated as a clean stop, not an error.
            if (ir[6:0] != 7'd0) illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          case (dec.cls)
            C_BRANCH: state <= S_FETCH;
            C_LOAD, C_STORE: begin
              wait_cnt <= '0;
              state    <= S_MEM;
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.dm_ready) begin
            state <= (dec.cls == C_LOAD) ? S_WB : S_FETCH;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= S_HALT;
            bus_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign bus.pc_we          = pc_we;
  assign bus.pc_sel         = pc_sel;
  assign bus.rf_we          = rf_we;
  assign bus.dm_we          = dm_we;
  assign bus.dm_re          = dm_re;
  assign bus.rs1            = dec.rs1;
  assign bus.rs2            = dec.rs2;
  assign bus.rd             = dec.rd;
  assign bus.func3          = dec.func3;
  assign bus.subsra         = dec.subsra;
  assign bus.mux_pc_reg1op  = dec.sel1;
  assign bus.mux_imm_reg2op = dec.sel2;
  assign bus.mux_wb_sel     = dec.wb;
  assign bus.br_opcode      = dec.br;
  assign bus.state          = state;
  assign bus.halted         = (state == S_HALT);
  assign bus.illegal        = illegal;
  assign bus.bus_err        = bus_err;
  assign bus.instret        = instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl (MEM_TIMEOUT = 4). Walks R, load with
//   memory wait, taken/not-taken branch, I-ALU (rd=0 and SRAI), JAL, store,
//   store timeout, illegal / zero opcode halts and reset during MEM.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  multicycle_ctrl_if #(.INSTRET_W(32)) bus ();

  multicycle_ctrl #(
    .MEM_TIMEOUT(4),
    .INSTRET_W  (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {pc_we, pc_sel, rf_we, dm_we, dm_re}
  task automatic strb(input string tag, input logic [4:0] exp);
    #1;
    chk(tag, {27'd0, bus.pc_we, bus.pc_sel, bus.rf_we, bus.dm_we, bus.dm_re}, {27'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    bus.instr        = 32'd0;
    bus.branch_taken = 1'b0;
    bus.dm_ready     = 1'b0;
    reset            = 1'b1;
    tick();
    tick();
    // Reset state, reset still asserted
    chk("rst_state",   32'(bus.state), 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    chk("rst_flags",   {29'd0, bus.halted, bus.illegal, bus.bus_err}, 32'd0);
    strb("rst_strb", 5'b00000);
    reset = 1'b0;

    // ---- add x3,x1,x2 ----
    bus.instr = 32'h002081B3;
    strb("add_f_strb", 5'b00000);
    chk("add_f_state", 32'(bus.state), 32'd0);
    tick();
    chk("add_d_state", 32'(bus.state), 32'd1);
    strb("add_d_strb", 5'b00000);
    tick();
    chk("add_e_state", 32'(bus.state), 32'd2);
    strb("add_e_strb", 5'b00000);
    chk("add_rd",  32'(bus.rd),  32'd3);
    chk("add_rs1", 32'(bus.rs1), 32'd1);
    chk("add_rs2", 32'(bus.rs2), 32'd2);
    chk("add_mux", {29'd0, bus.mux_pc_reg1op, bus.mux_wb_sel}, 32'b101);
    chk("add_sel2", 32'(bus.mux_imm_reg2op), 32'd0);
    chk("add_sub", 32'(bus.subsra), 32'd0);
    tick();
    chk("add_wb_state", 32'(bus.state), 32'd4);
    strb("add_wb_strb", 5'b10100);
    tick();
    chk("add_done_state", 32'(bus.state), 32'd0);
    chk("add_instret", bus.instret, 32'd1);

    // ---- lw x5,0(x1), dm_ready after 2 wait cycles ----
    bus.instr    = 32'h0000A283;
    bus.dm_ready = 1'b0;
    tick(); tick();
    chk("lw_e_state", 32'(bus.state), 32'd2);
    strb("lw_e_strb", 5'b00000);
    tick();
    chk("lw_m1_state", 32'(bus.state), 32'd3);
    strb("lw_m1_strb", 5'b00001);
    tick();
    chk("lw_m2_state", 32'(bus.state), 32'd3);
    strb("lw_m2_strb", 5'b00001);
    tick();
    bus.dm_ready = 1'b1;
    chk("lw_m3_state", 32'(bus.state), 32'd3);
    strb("lw_m3_strb", 5'b00001);
    tick();
    bus.dm_ready = 1'b0;
    chk("lw_wb_state", 32'(bus.state), 32'd4);
    strb("lw_wb_strb", 5'b10100);
    chk("lw_rd", 32'(bus.rd), 32'd5);
    chk("lw_wbsel", 32'(bus.mux_wb_sel), 32'd0);
    tick();
    chk("lw_done_state", 32'(bus.state), 32'd0);
    chk("lw_instret", bus.instret, 32'd2);

    // ---- beq x1,x2 taken then not taken ----
    for (int k = 0; k < 2; k++) begin
      bus.instr        = 32'h00208063;
      bus.branch_taken = (k == 0);
      tick(); tick();
      chk("beq_e_state", 32'(bus.state), 32'd2);
      strb("beq_e_strb", (k == 0) ? 5'b11000 : 5'b10000);
      chk("beq_br", 32'(bus.br_opcode), 32'd0);
      chk("beq_sel1", 32'(bus.mux_pc_reg1op), 32'd0);
      tick();
      chk("beq_done_state", 32'(bus.state), 32'd0);
      chk("beq_instret", bus.instret, 32'(3 + k));
    end
    bus.branch_taken = 1'b0;

    // ---- addi x0,x0,1 ----
    bus.instr = 32'h00100013;
    tick(); tick();
    chk("addi_br", 32'(bus.br_opcode), 32'h1F);
    tick();
    chk("addi_wb_state", 32'(bus.state), 32'd4);
    strb("addi_wb_strb", 5'b10000);
    tick();
    chk("addi_instret", bus.instret, 32'd5);

    // ---- srai x1,x1,3 ----
    bus.instr = 32'h4030D093;
    tick(); tick();
    chk("srai_sub", 32'(bus.subsra), 32'd1);
    chk("srai_f3", 32'(bus.func3), 32'd5);
    chk("srai_mux", {30'd0, bus.mux_pc_reg1op, bus.mux_imm_reg2op}, 32'b11);
    tick(); tick();
    chk("srai_instret", bus.instret, 32'd6);

    // ---- jal x1,0 ----
    bus.instr = 32'h000000EF;
    tick(); tick();
    chk("jal_br", 32'(bus.br_opcode), 32'h0F);
    chk("jal_mux", {30'd0, bus.mux_pc_reg1op, bus.mux_imm_reg2op}, 32'b01);
    tick();
    strb("jal_wb_strb", 5'b11100);
    chk("jal_wbsel", 32'(bus.mux_wb_sel), 32'd2);
    tick();
    chk("jal_instret", bus.instret, 32'd7);

    // ---- sw x2,0(x1), ready in the first MEM cycle ----
    bus.instr    = 32'h0020A023;
    bus.dm_ready = 1'b1;
    tick(); tick();
    chk("sw_rd", 32'(bus.rd), 32'd0);
    tick();
    chk("sw_m_state", 32'(bus.state), 32'd3);
    strb("sw_m_strb", 5'b10010);
    tick();
    chk("sw_done_state", 32'(bus.state), 32'd0);
    chk("sw_instret", bus.instret, 32'd8);

    // ---- sw with dm_ready held low: timeout ----
    bus.dm_ready = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      chk("swto_m_state", 32'(bus.state), 32'd3);
      strb("swto_m_strb", 5'b00010);
      tick();
    end
    chk("swto_state", 32'(bus.state), 32'd5);
    strb("swto_strb", 5'b00000);
    chk("swto_flags", {29'd0, bus.halted, bus.illegal, bus.bus_err}, 32'b101);
    chk("swto_instret", bus.instret, 32'd8);
    tick();
    chk("swto_stay", 32'(bus.state), 32'd5);

    // ---- unknown opcode 0x7F ----
    do_reset();
    chk("rst2_flags", {29'd0, bus.halted, bus.illegal, bus.bus_err}, 32'd0);
    chk("rst2_instret", bus.instret, 32'd0);
    bus.instr = 32'h0000007F;
    tick(); tick();
    chk("ill_state", 32'(bus.state), 32'd5);
    chk("ill_flags", {29'd0, bus.halted, bus.illegal, bus.bus_err}, 32'b110);
    tick(); tick();
    chk("ill_stay", {29'd0, bus.halted, bus.illegal, bus.bus_err}, 32'b110);

    // ---- all-zero word ----
    do_reset();
    bus.instr = 32'h00000000;
    tick(); tick();
    chk("zero_state", 32'(bus.state), 32'd5);
    chk("zero_flags", {29'd0, bus.halted, bus.illegal, bus.bus_err}, 32'b100);
    tick();
    chk("zero_stay", 32'(bus.halted), 32'd1);

    // ---- reset during MEM ----
    do_reset();
    bus.instr = 32'h00100013;
    tick(); tick(); tick(); tick();
    chk("pre_instret", bus.instret, 32'd1);
    bus.instr    = 32'h0000A283;
    bus.dm_ready = 1'b0;
    tick(); tick(); tick();
    strb("mrst_m_strb", 5'b00001);
    reset = 1'b1;
    tick();
    chk("mrst_state", 32'(bus.state), 32'd0);
    strb("mrst_strb", 5'b00000);
    chk("mrst_instret", bus.instret, 32'd0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I datapath (PC, instruction memory, register file, immediate unit, ALU, branch unit, data memory, write-back mux).
- Splits each instruction into FETCH/DECODE/EXEC/MEM/WB states and drives every write strobe and mux select.
- Adds a data-memory ready handshake with timeout, a halt state and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, maximum MEM-state cycles waiting for dm_ready before bus error (1..255).
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  instruction-memory output for current PC.
- branch_taken  in  1  branch-unit result, valid in EXEC.
- dm_ready  in  1  data memory has completed the current read/write.
- pc_we  out  1  PC load strobe.
- pc_sel  out  1  0 = PC+4 (sum), 1 = ALU target.
- rf_we  out  1  register-file write enable.
- dm_we  out  1  data-memory write request.
- dm_re  out  1  data-memory read request.
- rs1, rs2, rd  out  5 each  register indices.
- func3  out  3  ALU/DM control.
- subsra  out  1  ALU sub/sra select.
- mux_pc_reg1op  out  1  1 = rs1, 0 = PC into ALU operand 1.
- mux_imm_reg2op  out  1  1 = imm, 0 = rs2 into ALU operand 2.
- mux_wb_sel  out  2  00 = DM, 01 = ALU, 10 = PC+4.
- br_opcode  out  5  branch-unit op; 11111 = never, 01111 = always.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- halted  out  1  high in HALT.
- illegal  out  1  sticky: unknown opcode caused halt.
- bus_err  out  1  sticky: MEM timeout caused halt.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
Reset:
- state=FETCH; IR, decode register, wait counter and instret are 0.
- illegal=0, bus_err=0, halted=0.
- All strobes (pc_we, rf_we, dm_we, dm_re) are 0.
- Reset has priority in every state, including mid-MEM; any pending DM request drops the next cycle.

Output timing:
- Strobes and selects are combinational from state plus the decode register.
- The decode register is loaded only on leaving DECODE.

FETCH:
- IR <= instr.
- Always go to DECODE.

DECODE: decode IR[6:0] into the decode register, using the same field/select mapping as the single-cycle control.
- 0110011 R: mux sel 1/0; wb=01; subsra=IR[30].
- 0010011 I-ALU: sel 1/1; wb=01; subsra=IR[30] only when func3=101, else 0.
- 0000011 load: sel 1/1; wb=00.
- 0100011 store: sel 1/1; rd forced to 0.
- 1100011 branch: sel 0/1; br_opcode={2'b00,func3}.
- 1100111 JALR: sel 1/1; wb=10; br=01111.
- 1101111 JAL: sel 0/1; wb=10; br=01111.
- 0110111 LUI: sel 0/1; wb=01.
- Next state: opcode 0000000 -> HALT (illegal stays 0); any other unknown opcode -> HALT with illegal<=1; otherwise -> EXEC.

EXEC:
- R/I/LUI/JAL/JALR -> WB.
- Load/store -> MEM; wait counter cleared.
- Branch: pc_we=1, pc_sel=branch_taken; instret++; -> FETCH.

MEM:
- dm_re (load) or dm_we (store) held high every MEM cycle until dm_ready is sampled high.
- dm_ready high: load -> WB; store asserts pc_we=1, pc_sel=0 that cycle, instret++, -> FETCH.
- dm_ready low: counter++. When counter reaches MEM_TIMEOUT-1 with dm_ready still low -> HALT with bus_err<=1; no write-back, no PC update.

WB:
- rf_we=1 unless rd==0.
- pc_we=1; pc_sel=1 for JAL/JALR, else 0.
- instret++; -> FETCH.

HALT:
- All strobes 0; halted=1.
- Remains in HALT until reset.

Latency (dm_ready in first MEM cycle):
- Branch 3 cycles.
- R/I/LUI/JAL/JALR 4 cycles.
- Store 4 cycles.
- Load 5 cycles.
- Each dm_ready wait adds 1 cycle.

Arithmetic and exclusivity:
- instret wraps modulo 2^INSTRET_W.
- pc_we, rf_we, dm_we are never high in the same cycle as a state with no legal use of them.
- dm_re and dm_we are mutually exclusive.

Test Plan:
- Reset then R-type add x3,x1,x2 (0x002081B3) -> states 0,1,2,4; rf_we=1, rd=3, wb=01, pc_we=1, pc_sel=0 in WB only; instret=1.
- Load lw x5,0(x1) with dm_ready delayed 2 cycles -> dm_re high 3 MEM cycles, no rf_we until WB; rf_we=1, rd=5, wb=00; total 7 cycles.
- beq taken (branch_taken=1) then beq not taken -> EXEC pc_we=1 with pc_sel=1 then 0; rf_we never high; br_opcode=00000.
- Store with dm_ready held low, MEM_TIMEOUT=4 -> dm_we high for 4 cycles, then state=HALT, bus_err=1, pc_we never asserted, instret unchanged.
- Opcode 0x7F, then separately 0x00000000 -> HALT; illegal=1 for the first, 0 for the second; halted=1 and stays high.
- addi x0,x0,1 (rd=0) -> rf_we stays 0 in WB, pc_we=1. Reset asserted mid-MEM -> next cycle state=0, dm_re=0, counters cleared.
